matrix_mul_seq: RTL and testbench
=================================

Name: matrix_mul_seq

Overview:
Parametrised sequential NxN unsigned matrix multiplier. It is the clocked successor to the combinational 4x4 multiplier. Operands A and B stream in through a valid/ready port in row-major order. A single MAC computes C = A x B, and C streams out through a valid/ready port with an end-of-matrix marker. It also adds an optional saturating result mode and a per-element overflow flag.

Parameters:
N, 4, matrix dimension (N >= 2)
DATA_W, 16, element width of A, B and C
SATURATE, 0, 0 = C element keeps low DATA_W bits of the sum (wrap); 1 = clamp to 2^DATA_W-1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts operand beat
in_data  input  DATA_W  operand element; A[0..N*N-1] then B[0..N*N-1], row-major
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result beat
out_data  output  DATA_W  C element, row-major
out_ovf  output  1  full-precision sum of this element exceeded 2^DATA_W-1
out_last  output  1  marks beat C[N*N-1]
busy  output  1  high in COMPUTE and OUTPUT

Behaviour:
- Reset (rst_n low at a clk edge): state LOAD_A, all counters 0, in_ready=1, out_valid=0, out_data=0, out_ovf=0, out_last=0, busy=0. The accumulator and C store are cleared. Reset wins over every other event, in any state.
- Internal accumulator width is ACC_W = 2*DATA_W + clog2(N). Products and sums never lose bits before the final conversion.
- State LOAD_A: in_ready=1. Each beat with in_valid&in_ready writes A[idx] and increments idx. After beat N*N-1: idx=0, go to LOAD_B.
- State LOAD_B: same as LOAD_A, filling B. After beat N*N-1, go to COMPUTE on the next cycle. in_ready=0 from that cycle on.
- State COMPUTE: exactly one MAC per cycle, acc += A[i][k]*B[k][j], with k inner, j middle and i outer.
  - On k=N-1 the full sum is converted and written to C[i][j], and acc is cleared.
  - Conversion when SATURATE=0: take sum mod 2^DATA_W.
  - Conversion when SATURATE=1: take min(sum, 2^DATA_W-1).
  - The ovf bit for C[i][j] is (sum > 2^DATA_W-1) in both modes.
  - COMPUTE lasts exactly N*N*N cycles. The next cycle is OUTPUT with out_valid=1 presenting C[0].
- State OUTPUT: out_data, out_ovf and out_last reflect C[odx].
  - While out_valid&!out_ready, all outputs hold stable.
  - Each accepted beat increments odx. The new element appears in the following cycle with no bubble.
  - out_last=1 only when odx=N*N-1.
  - Acceptance of the last beat sets state LOAD_A, out_valid=0 and in_ready=1 in the next cycle.
- in_valid is ignored outside the LOAD states. out_ready is ignored outside OUTPUT.
- Total latency from the last B beat accepted to the first out_valid is N^3+1 cycles.
- Operands are unsigned. No partial-matrix abort exists other than rst_n.

Test Plan:
- N=4, DATA_W=16, SATURATE=0. Load A=identity and B rows {5,10,15,20},{6,11,16,21},{7,12,17,22},{8,13,18,23}, with out_ready=1. Required: C equals B element-for-element, out_ovf=0 on all beats, out_last only on the 16th beat, and the first out_valid exactly 65 cycles after the last B beat.
- General product: A rows {1,2,3,4}x4 times B = the matrix above. Required: every C row = {70,120,170,220}.
- Backpressure: drive out_ready with pattern 1,0,0,1,... during OUTPUT. Required: out_data/out_ovf/out_last stable through stall cycles, with no duplicated or dropped element. Next A beat accepted the cycle after the final handshake.
- Overflow: A and B all 256.
  - SATURATE=0: every C=0 (262144 mod 65536) with out_ovf=1.
  - SATURATE=1: every C=65535 with out_ovf=1.
  - Boundary case A[0]=255, B[0]=257, rest 0: C[0]=65535, out_ovf=0.
- Reset mid-operation: assert rst_n=0 for one cycle during COMPUTE (cycle 30) and, separately, during a stalled OUTPUT. Required: next cycle state LOAD_A, in_ready=1, out_valid=0, busy=0. A fresh identity x B run then produces a correct C with no residue.
- Parameter sweep N=2, DATA_W=8: A={1,2,3,4}, B={5,6,7,8}. Required: C={19,22,43,50}, and COMPUTE lasts 8 cycles.

Source files
------------

// File: rtl/matrix_mul_seq_if.sv
// Operand and result streaming bundle for the sequential matrix multiplier.
// The master side feeds operands and consumes results; the slave side is the
// multiplier itself. DATA_W here must match the multiplier's DATA_W.
interface matrix_mul_seq_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_ovf;
    logic              out_last;
    logic              busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_last, busy
    );
endinterface

// File: rtl/matrix_mul_seq.sv
// Sequential NxN unsigned matrix multiplier built around one MAC.
// A then B stream in row-major, C = A x B is computed one product per cycle
// (k inner, j middle, i outer) and C streams out with an end-of-matrix flag.
// Each C element carries an overflow flag; SATURATE selects wrap or clamp.
module matrix_mul_seq #(
    parameter int N        = 4,
    parameter int DATA_W   = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    matrix_mul_seq_if.slave  bus
);

    localparam int NN    = N * N;
    localparam int IDX_W = $clog2(NN);
    localparam int CNT_W = $clog2(N);
    // Wide enough for N full-width products, so no bits drop before conversion.
    localparam int ACC_W = 2 * DATA_W + $clog2(N);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NN - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
    localparam logic [ACC_W-1:0] MAX_ELEM = {{(ACC_W - DATA_W){1'b0}}, {DATA_W{1'b1}}};

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        COMPUTE,
        OUTPUT
    } state_t;

    state_t state;
    state_t next_state;

    logic [DATA_W-1:0] a_mem [NN];
    logic [DATA_W-1:0] b_mem [NN];
    logic [DATA_W-1:0] c_mem [NN];
    logic [NN-1:0]     c_ovf;

    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  odx;
    logic [CNT_W-1:0]  i_cnt;
    logic [CNT_W-1:0]  j_cnt;
    logic [CNT_W-1:0]  k_cnt;
    logic [ACC_W-1:0]  acc;

    logic              in_ready_s;
    logic              out_valid_s;
    logic              busy_s;
    logic              in_fire;
    logic              out_fire;
    logic              k_last;
    logic              mac_last;

    logic [IDX_W-1:0]  a_addr;
    logic [IDX_W-1:0]  b_addr;
    logic [IDX_W-1:0]  c_addr;
    logic [ACC_W-1:0]  product;
    logic [ACC_W-1:0]  sum;
    logic              sum_ovf;
    logic [DATA_W-1:0] sum_conv;

    assign in_fire  = bus.in_valid && in_ready_s;
    assign out_fire = out_valid_s && bus.out_ready;
    assign k_last   = (k_cnt == LAST_CNT);
    assign mac_last = k_last && (j_cnt == LAST_CNT) && (i_cnt == LAST_CNT);

    // MAC datapath: current product, running sum and its conversion to a C element.
    always_comb begin
        a_addr   = IDX_W'(int'(i_cnt) * N + int'(k_cnt));
        b_addr   = IDX_W'(int'(k_cnt) * N + int'(j_cnt));
        c_addr   = IDX_W'(int'(i_cnt) * N + int'(j_cnt));
        product  = ACC_W'(a_mem[a_addr]) * ACC_W'(b_mem[b_addr]);
        sum      = acc + product;
        sum_ovf  = (sum > MAX_ELEM);
        sum_conv = sum[DATA_W-1:0];
        if ((SATURATE != 0) && sum_ovf) begin
            sum_conv = {DATA_W{1'b1}};
        end
    end

    // State register; reset always returns to loading A.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= LOAD_A;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        next_state  = state;
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
        case (state)
            LOAD_A: begin
                in_ready_s = 1'b1;
                if (bus.in_valid && (idx == LAST_IDX)) begin
                    next_state = LOAD_B;
                end
            end
            LOAD_B: begin
                in_ready_s = 1'b1;
                if (bus.in_valid && (idx == LAST_IDX)) begin
                    next_state = COMPUTE;
                end
            end
            COMPUTE: begin
                busy_s = 1'b1;
                if (mac_last) begin
                    next_state = OUTPUT;
                end
            end
            OUTPUT: begin
                busy_s      = 1'b1;
                out_valid_s = 1'b1;
                if (bus.out_ready && (odx == LAST_IDX)) begin
                    next_state = LOAD_A;
                end
            end
            default: next_state = LOAD_A;
        endcase
    end

    // Operand capture; the operand stores need no reset since they are always
    // fully rewritten before COMPUTE reads them.
    always_ff @(posedge clk) begin
        if (in_fire && (state == LOAD_A)) begin
            a_mem[idx] <= bus.in_data;
        end
        if (in_fire && (state == LOAD_B)) begin
            b_mem[idx] <= bus.in_data;
        end
    end

    // Counters, accumulator and result store.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx   <= '0;
            odx   <= '0;
            i_cnt <= '0;
            j_cnt <= '0;
            k_cnt <= '0;
            acc   <= '0;
            c_ovf <= '0;
            for (int e = 0; e < NN; e++) begin
                c_mem[e] <= '0;
            end
        end else begin
            case (state)
                LOAD_A, LOAD_B: begin
                    if (in_fire) begin
                        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                    end
                end
                COMPUTE: begin
                    if (k_last) begin
                        c_mem[c_addr] <= sum_conv;
                        c_ovf[c_addr] <= sum_ovf;
                        acc           <= '0;
                        k_cnt         <= '0;
                        if (j_cnt == LAST_CNT) begin
                            j_cnt <= '0;
                            i_cnt <= (i_cnt == LAST_CNT) ? '0 : i_cnt + 1'b1;
                        end else begin
                            j_cnt <= j_cnt + 1'b1;
                        end
                    end else begin
                        acc   <= sum;
                        k_cnt <= k_cnt + 1'b1;
                    end
                end
                OUTPUT: begin
                    if (out_fire) begin
                        odx <= (odx == LAST_IDX) ? '0 : odx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.busy      = busy_s;
    assign bus.out_data  = (state == OUTPUT) ? c_mem[odx] : '0;
    assign bus.out_ovf   = (state == OUTPUT) ? c_ovf[odx] : 1'b0;
    assign bus.out_last  = (state == OUTPUT) && (odx == LAST_IDX);

endmodule

// File: tb/tb_matrix_mul_seq.sv
// Bench for matrix_mul_seq: three instances (4x4 wrap, 4x4 saturate, 2x2 8-bit)
// driven one at a time and checked against a plain matrix-product model.
module tb_matrix_mul_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_ready;
    int          sel;

    logic        obs_in_ready;
    logic        obs_valid;
    logic [15:0] obs_data;
    logic        obs_ovf;
    logic        obs_last;
    logic        obs_busy;

    int          errors = 0;
    int          checks = 0;

    int unsigned a_m [16];
    int unsigned b_m [16];
    int unsigned exp_c [16];
    bit          exp_ovf [16];
    int          cur_n;
    int          cur_w;
    int          cur_sat;

    always #5 clk = ~clk;

    matrix_mul_seq_if #(.DATA_W(16)) mif0 ();
    matrix_mul_seq_if #(.DATA_W(16)) mif1 ();
    matrix_mul_seq_if #(.DATA_W(8))  mif2 ();

    assign mif0.in_valid  = in_valid && (sel == 0);
    assign mif1.in_valid  = in_valid && (sel == 1);
    assign mif2.in_valid  = in_valid && (sel == 2);
    assign mif0.in_data   = in_data;
    assign mif1.in_data   = in_data;
    assign mif2.in_data   = in_data[7:0];
    assign mif0.out_ready = out_ready && (sel == 0);
    assign mif1.out_ready = out_ready && (sel == 1);
    assign mif2.out_ready = out_ready && (sel == 2);

    matrix_mul_seq #(.N(4), .DATA_W(16), .SATURATE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(mif0.slave));
    matrix_mul_seq #(.N(4), .DATA_W(16), .SATURATE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(mif1.slave));
    matrix_mul_seq #(.N(2), .DATA_W(8),  .SATURATE(0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(mif2.slave));

    // Present the selected instance's outputs on one set of observation signals.
    always_comb begin
        obs_in_ready = mif0.in_ready;
        obs_valid    = mif0.out_valid;
        obs_data     = mif0.out_data;
        obs_ovf      = mif0.out_ovf;
        obs_last     = mif0.out_last;
        obs_busy     = mif0.busy;
        if (sel == 1) begin
            obs_in_ready = mif1.in_ready;
            obs_valid    = mif1.out_valid;
            obs_data     = mif1.out_data;
            obs_ovf      = mif1.out_ovf;
            obs_last     = mif1.out_last;
            obs_busy     = mif1.busy;
        end else if (sel == 2) begin
            obs_in_ready = mif2.in_ready;
            obs_valid    = mif2.out_valid;
            obs_data     = {8'h00, mif2.out_data};
            obs_ovf      = mif2.out_ovf;
            obs_last     = mif2.out_last;
            obs_busy     = mif2.busy;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dut(input int s);
        sel     = s;
        cur_n   = (s == 2) ? 2 : 4;
        cur_w   = (s == 2) ? 8 : 16;
        cur_sat = (s == 1) ? 1 : 0;
    endtask

    // Reference: textbook C[i][j] = sum_k A[i][k]*B[k][j] in 64-bit, then
    // wrap or clamp to the element width.
    function automatic void build_ref();
        longint unsigned maxv;
        longint unsigned s;
        maxv = (64'd1 << cur_w) - 64'd1;
        for (int i = 0; i < cur_n; i++) begin
            for (int j = 0; j < cur_n; j++) begin
                s = 0;
                for (int k = 0; k < cur_n; k++) begin
                    s += longint'(a_m[i*cur_n+k]) * longint'(b_m[k*cur_n+j]);
                end
                exp_ovf[i*cur_n+j] = (s > maxv);
                if (s <= maxv)        exp_c[i*cur_n+j] = int'(s);
                else if (cur_sat != 0) exp_c[i*cur_n+j] = int'(maxv);
                else                   exp_c[i*cur_n+j] = int'(s % (maxv + 1));
            end
        end
    endfunction

    task automatic randomize_ops();
        int unsigned maxv;
        maxv = (32'd1 << cur_w) - 1;
        for (int e = 0; e < cur_n * cur_n; e++) begin
            a_m[e] = $urandom_range(0, maxv);
            b_m[e] = $urandom_range(0, maxv);
        end
    endtask

    task automatic identity_times_b();
        int unsigned brow [16] = '{5,10,15,20, 6,11,16,21, 7,12,17,22, 8,13,18,23};
        for (int e = 0; e < 16; e++) begin
            a_m[e] = ((e / 4) == (e % 4)) ? 1 : 0;
            b_m[e] = brow[e];
        end
    endtask

    task automatic applyStimulus();
        int nn;
        int waited;
        nn = cur_n * cur_n;
        for (int beat = 0; beat < 2 * nn; beat++) begin
            in_valid = 1'b1;
            in_data  = (beat < nn) ? 16'(a_m[beat]) : 16'(b_m[beat-nn]);
            waited   = 0;
            while (!obs_in_ready && waited < 20) begin
                step();
                waited++;
            end
            if (!obs_in_ready) begin
                errors++;
                checks++;
                $display("[TB] FAIL load_timeout: beat %0d in_ready got 0 expected 1", beat);
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    // Count cycles from the one after the last B beat until out_valid.
    task automatic wait_result(output int lat, output int comp);
        lat  = 1;
        comp = 0;
        while (!obs_valid && lat < 1000) begin
            if (obs_busy && !obs_in_ready) comp++;
            step();
            lat++;
        end
        if (!obs_valid) begin
            errors++;
            checks++;
            $display("[TB] FAIL result_timeout: out_valid got 0 expected 1");
        end
    endtask

    // Drain C; mode 0 = always ready, 1 = ready every third cycle, 2 = random.
    task automatic checkOutput(input int mode);
        int          nn;
        int          beat;
        int          cyc;
        bit          rdy;
        bit          have_hold;
        logic [17:0] held;
        logic [17:0] want;
        nn        = cur_n * cur_n;
        beat      = 0;
        cyc       = 0;
        have_hold = 0;
        held      = '0;
        while (beat < nn && cyc < 2000) begin
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = ((cyc % 3) == 0);
            else                rdy = 1'($urandom_range(0, 1));
            out_ready = rdy;
            checks++;
            if (obs_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL out_valid_held: beat %0d got %0b expected 1", beat, obs_valid);
            end
            if (have_hold) begin
                checks++;
                if ({obs_data, obs_ovf, obs_last} !== held) begin
                    errors++;
                    $display("[TB] FAIL stall_stable: beat %0d got %h expected %h", beat,
                             {obs_data, obs_ovf, obs_last}, held);
                end
            end
            if (rdy) begin
                want = {16'(exp_c[beat]), exp_ovf[beat], (beat == nn - 1)};
                checks++;
                if ({obs_data, obs_ovf, obs_last} !== want) begin
                    errors++;
                    $display("[TB] FAIL c_beat: beat %0d got data=%0d ovf=%0b last=%0b expected data=%0d ovf=%0b last=%0b",
                             beat, obs_data, obs_ovf, obs_last, want[17:2], want[1], want[0]);
                end
                beat++;
                have_hold = 0;
            end else begin
                held      = {obs_data, obs_ovf, obs_last};
                have_hold = 1;
            end
            step();
            cyc++;
        end
        out_ready = 1'b0;
        if (beat < nn) begin
            errors++;
            checks++;
            $display("[TB] FAIL drain_timeout: beats got %0d expected %0d", beat, nn);
        end
        checks++;
        if ({obs_in_ready, obs_valid, obs_busy} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL back_to_load: ready/valid/busy got %b expected 100",
                     {obs_in_ready, obs_valid, obs_busy});
        end
    endtask

    task automatic run_full(input int mode);
        int lat;
        int comp;
        build_ref();
        applyStimulus();
        wait_result(lat, comp);
        checks++;
        if (lat !== cur_n * cur_n * cur_n + 1) begin
            errors++;
            $display("[TB] FAIL latency: got %0d expected %0d", lat, cur_n * cur_n * cur_n + 1);
        end
        checks++;
        if (comp !== cur_n * cur_n * cur_n) begin
            errors++;
            $display("[TB] FAIL compute_cycles: got %0d expected %0d", comp, cur_n * cur_n * cur_n);
        end
        checkOutput(mode);
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({obs_in_ready, obs_valid, obs_busy, obs_data, obs_ovf, obs_last} !== {3'b100, 16'h0, 2'b00}) begin
            errors++;
            $display("[TB] FAIL %s: ready/valid/busy=%b data=%0d ovf=%0b last=%0b expected 100 0 0 0",
                     name, {obs_in_ready, obs_valid, obs_busy}, obs_data, obs_ovf, obs_last);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        set_dut(0);
        step();
        step();
        rst_n = 1'b1;
        for (int s = 0; s < 3; s++) begin
            set_dut(s);
            #1;
            check_idle("reset_state");
        end
    endtask

    task automatic test_identity();
        set_dut(0);
        identity_times_b();
        run_full(0);
    endtask

    task automatic test_general();
        set_dut(0);
        identity_times_b();
        for (int e = 0; e < 16; e++) a_m[e] = (e % 4) + 1;
        build_ref();
        checks++;
        if (exp_c[5] !== 120) begin
            errors++;
            $display("[TB] FAIL model_general: got %0d expected 120", exp_c[5]);
        end
        run_full(0);
    endtask

    task automatic test_back_to_back();
        set_dut(0);
        randomize_ops();
        run_full(1);
        identity_times_b();
        run_full(1);
        set_dut(1);
        randomize_ops();
        run_full(1);
    endtask

    task automatic test_overflow();
        for (int s = 0; s < 2; s++) begin
            set_dut(s);
            for (int e = 0; e < 16; e++) begin
                a_m[e] = 256;
                b_m[e] = 256;
            end
            run_full(0);
            for (int e = 0; e < 16; e++) begin
                a_m[e] = 0;
                b_m[e] = 0;
            end
            a_m[0] = 255;
            b_m[0] = 257;
            run_full(0);
        end
    endtask

    task automatic test_reset_compute();
        int lat;
        set_dut(0);
        randomize_ops();
        applyStimulus();
        lat = 1;
        while (lat < 30) begin
            step();
            lat++;
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle("reset_in_compute");
        identity_times_b();
        run_full(0);
    endtask

    task automatic test_reset_output();
        int lat;
        int comp;
        set_dut(1);
        randomize_ops();
        build_ref();
        applyStimulus();
        wait_result(lat, comp);
        out_ready = 1'b0;
        step();
        step();
        checks++;
        if (obs_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stalled_output: out_valid got %0b expected 1", obs_valid);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle("reset_in_output");
        identity_times_b();
        run_full(2);
    endtask

    task automatic test_small();
        set_dut(2);
        a_m[0] = 1; a_m[1] = 2; a_m[2] = 3; a_m[3] = 4;
        b_m[0] = 5; b_m[1] = 6; b_m[2] = 7; b_m[3] = 8;
        run_full(0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            set_dut(r % 3);
            randomize_ops();
            run_full(2);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_general();
        test_back_to_back();
        test_overflow();
        test_reset_compute();
        test_reset_output();
        test_small();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
